// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular FIFO of {inst, pc, pred_taken}
// with show-ahead head presentation, one-cycle misprediction clear and global stall.
module inst_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        if_valid,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    input  logic        if_pred_taken,
    output logic        iq_full,
    input  logic        dec_ready,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_pred_taken,
    output logic [6:0]  out_inst_type
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred_taken;
    } iq_entry_t;

    iq_entry_t          mem_q [DEPTH];
    logic [ADDR_W-1:0]  head_q, head_d;
    logic [ADDR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop, wr_en;
    iq_entry_t          head_entry;

    assign out_valid = (count_q != '0);
    assign iq_full   = (count_q == FULL_CNT);
    assign push      = if_valid && !iq_full;
    assign pop       = out_valid && dec_ready;
    assign wr_en     = rdy_in && !clear_in && push;

    // Pointer/count next state: freeze beats clear, clear beats push/pop
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy_in) begin
            if (clear_in) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push) begin
                    tail_d = tail_q + ADDR_W'(1);
                end
                if (pop) begin
                    head_d = head_q + ADDR_W'(1);
                end
                if (push && !pop) begin
                    count_d = count_q + CNT_W'(1);
                end else if (pop && !push) begin
                    count_d = count_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; out_valid gates everything read from it
    always_ff @(posedge clk_in) begin
        if (rst_in && wr_en) begin
            mem_q[tail_q] <= '{inst: if_inst, pc: if_pc, pred_taken: if_pred_taken};
        end
    end

    assign head_entry = mem_q[head_q];

    always_comb begin
        out_inst       = '0;
        out_pc         = '0;
        out_pred_taken = 1'b0;
        if (out_valid) begin
            out_inst       = head_entry.inst;
            out_pc         = head_entry.pc;
            out_pred_taken = head_entry.pred_taken;
        end
    end

    assign out_inst_type = out_inst[6:0];

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, show-ahead push/pop, fill and wrap,
// streaming push/pop, clear with push, freeze, and mid-operation reset.
module tb_inst_queue;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        iq_full;
    logic        dec_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_pred_taken;
    logic [6:0]  out_inst_type;

    int n_chk  = 0;
    int n_pass = 0;

    inst_queue #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clear_in       (clear_in),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .iq_full        (iq_full),
        .dec_ready      (dec_ready),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_pred_taken (out_pred_taken),
        .out_inst_type  (out_inst_type)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it
    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] inst_of(input int k);
        return {8'hA5, 8'(k), 9'd0, 7'(k + 3)};
    endfunction

    task automatic set_push(input int k);
        if_valid      = 1'b1;
        if_inst       = inst_of(k);
        if_pc         = 32'(k * 4);
        if_pred_taken = 1'(k & 1);
    endtask

    task automatic check_head(input string tag, input int k);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_pc"}, out_pc, 32'(k * 4));
        chk({tag, "_inst"}, out_inst, inst_of(k));
        chk({tag, "_pred"}, 32'(out_pred_taken), 32'(k & 1));
        chk({tag, "_type"}, 32'(out_inst_type), 32'(7'(k + 3)));
    endtask

    task automatic check_empty(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_full"}, 32'(iq_full), 32'd0);
        chk({tag, "_inst"}, out_inst, 32'd0);
        chk({tag, "_pc"}, out_pc, 32'd0);
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
        if_valid = 1'b0; if_inst = '0; if_pc = '0; if_pred_taken = 1'b0;
        dec_ready = 1'b0;

        // Reset held two cycles, then idle
        for (int i = 0; i < 2; i++) begin
            cyc();
            check_empty("reset");
        end
        rst_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            check_empty("idle");
        end

        // Single push, visible next cycle, then one pop
        if_valid = 1'b1; if_inst = 32'h0050_0093; if_pc = 32'h0; if_pred_taken = 1'b0;
        chk("nobypass_valid", 32'(out_valid), 32'd0);
        cyc();
        if_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_inst", out_inst, 32'h0050_0093);
        chk("single_type", 32'(out_inst_type), 32'h13);
        chk("single_pc", out_pc, 32'h0);
        dec_ready = 1'b1;
        cyc();
        dec_ready = 1'b0;
        check_empty("single_pop");
        dec_ready = 1'b1;
        cyc();
        dec_ready = 1'b0;
        check_empty("pop_empty");

        // Fill 16 entries; full only after the 16th
        for (int i = 0; i < 16; i++) begin
            set_push(i);
            cyc();
            chk("fill_full", 32'(iq_full), 32'(i == 15));
            check_head("fill_head", 0);
        end
        set_push(16);
        cyc();
        if_valid = 1'b0;
        chk("refused_full", 32'(iq_full), 32'd1);
        check_head("refused_head", 0);

        // Pop 4, full drops after the first pop
        for (int i = 0; i < 4; i++) begin
            check_head("pop4", i);
            dec_ready = 1'b1;
            cyc();
            chk("pop4_full", 32'(iq_full), 32'd0);
        end
        dec_ready = 1'b0;
        for (int i = 16; i < 20; i++) begin
            set_push(i);
            cyc();
        end
        if_valid = 1'b0;
        chk("refill_full", 32'(iq_full), 32'd1);
        for (int k = 4; k < 20; k++) begin
            check_head("drain", k);
            dec_ready = 1'b1;
            cyc();
        end
        dec_ready = 1'b0;
        check_empty("drained");

        // Simultaneous push/pop at count 5
        for (int k = 20; k < 25; k++) begin
            set_push(k);
            cyc();
        end
        for (int j = 0; j < 10; j++) begin
            set_push(25 + j);
            dec_ready = 1'b1;
            check_head("stream", 20 + j);
            chk("stream_full", 32'(iq_full), 32'd0);
            cyc();
        end
        if_valid = 1'b0;
        for (int k = 30; k < 35; k++) begin
            check_head("stream_drain", k);
            cyc();
        end
        dec_ready = 1'b0;
        check_empty("stream_end");

        // Clear at count 7 together with a push and a pop
        for (int k = 40; k < 47; k++) begin
            set_push(k);
            cyc();
        end
        set_push(47);
        clear_in = 1'b1;
        dec_ready = 1'b1;
        cyc();
        clear_in = 1'b0;
        if_valid = 1'b0;
        dec_ready = 1'b0;
        check_empty("clear");
        set_push(48);
        cyc();
        if_valid = 1'b0;
        check_head("post_clear", 48);
        dec_ready = 1'b1;
        cyc();
        dec_ready = 1'b0;
        check_empty("post_clear_pop");

        // Freeze at count 3 with every other control active
        for (int k = 50; k < 53; k++) begin
            set_push(k);
            cyc();
        end
        rdy_in = 1'b0;
        set_push(53);
        dec_ready = 1'b1;
        clear_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_head("freeze", 50);
            chk("freeze_full", 32'(iq_full), 32'd0);
        end
        rdy_in = 1'b1;
        clear_in = 1'b0;
        if_valid = 1'b0;
        for (int k = 50; k < 53; k++) begin
            check_head("resume", k);
            cyc();
        end
        dec_ready = 1'b0;
        check_empty("resume_end");

        // Reset mid-operation discards entries
        for (int k = 60; k < 62; k++) begin
            set_push(k);
            cyc();
        end
        if_valid = 1'b0;
        check_head("pre_reset", 60);
        rst_in = 1'b0;
        cyc();
        check_empty("mid_reset");
        rst_in = 1'b1;
        cyc();
        check_empty("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
